iob_timer_mc: RTL
=================

# iob_timer_mc

Multi-channel, parametrised successor to the single 64-bit free-running timer. It provides N_CH independent up-counters behind one native CPU slave port. Each counter has a compare register, one-shot or periodic mode, a sticky match flag and an interrupt enable. It sits as a peripheral on the SoC native interconnect and drives a single interrupt line plus a per-channel interrupt vector.

## Interface
- N_CH, 4: number of channels, 1..16.
- CNT_W, 32: counter and compare width, 1..32.
- DATA_W, 32: CPU data width, fixed at 32.
- ADDR_W, $clog2(N_CH)+2: word address width.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- valid  in  1  request strobe.
- address  in  ADDR_W  word address: {channel, reg[1:0]}.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  write strobes; any nonzero value is a full-word write, zero is a read.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  one-cycle acknowledge.
- irq  out  1  OR of irq_vec.
- irq_vec  out  N_CH  per channel: flag & IRQ_EN.

## Operation
- Per-channel registers. Reads zero-extend to 32 bits. Write bits above CNT_W are ignored.
  - reg 0, CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[15:8] PRESC (only with the macro).
  - reg 1, CMP.
  - reg 2, CNT: read returns the current count. A write loads the count.
  - reg 3, STATUS: bit0 FLAG. Writing 1 clears it; writing 0 has no effect.
- Tick: while EN=1, one tick per PRESC+1 clock cycles. Without the macro, one tick every cycle.
- On each tick:
  - If CNT==CMP: set FLAG.
    - PERIODIC=1: CNT←0.
    - PERIODIC=0: CNT holds and EN←0.
  - Otherwise CNT←CNT+1, modulo 2^CNT_W.
- Period is CMP+1 ticks. CMP=0 in periodic mode sets FLAG on every tick.
- CNT loaded above CMP counts up to all-ones, wraps to 0, then matches CMP.
- EN=0 freezes CNT and the prescaler. Re-enabling resumes from the frozen values.
- Clearing EN does not clear FLAG.
- Accesses to a channel index ≥ N_CH: reads return 0, writes are ignored, ready is still returned.

## Timing
- Reset (synchronous): all of the following are 0, including irq.
  - Per channel: CTRL, CMP, CNT, FLAG, prescaler count.
  - Outputs: ready, rdata, irq_vec, irq.
- Handshake:
  - ready=1 exactly one cycle after each cycle with valid=1.
  - rdata is registered and valid in that same cycle.
  - The master holds valid for one cycle per request; back-to-back requests are accepted every cycle.
- Write latency: a register written at edge t shows the new value at t+1.
  - A read in the cycle after a write returns the new value.
- Tick matching at edge t: FLAG=1 and irq_vec/irq=1 after edge t, with zero extra cycles.
  - irq is combinational from registered FLAG and IRQ_EN.
- Simultaneous events at one edge:
  - CNT write and tick on the same channel: the write wins and the tick is lost.
  - STATUS clear and match: set wins, so FLAG stays 1.
  - CTRL write setting EN: the first tick occurs at the earliest 1 cycle later (prescaler restarts at 0).
  - CTRL write changing PRESC resets the prescaler count to 0.
- rst asserted mid-operation overrides every other update at that edge. A pending ready is dropped.

## Configuration
- TIMER_PRESCALER_EN defined:
  - Each channel has an 8-bit prescaler counter.
  - PRESC is held in CTRL[15:8], which is readable and writable.
- TIMER_PRESCALER_EN undefined:
  - No prescaler logic is built.
  - Ticks occur every enabled cycle.
  - CTRL[15:8] reads 0 and writes to it are ignored.

## Test plan
- Reset: pulse rst for 2 cycles, then read every register of every channel → all 0, irq=0, ready pulses once per read.
- Periodic: ch0 CMP=4, CTRL=0b111 → FLAG/irq set every 5 cycles. Write STATUS=1 → FLAG clears, then re-sets 5 ticks later.
- One-shot: ch1 CMP=3, CTRL=0b001 → after 4 ticks FLAG=1, CNT=3, CTRL.EN reads 0. irq stays 0 because IRQ_EN=0.
- Wrap: CNT_W=8, ch2 CMP=2, write CNT=0xFE, enable periodic → CNT sequence 0xFE, 0xFF, 0x00, 0x01, 0x02, match, 0x00.
- Collisions:
  - STATUS clear in the same cycle as a match → FLAG=1.
  - CNT write of 0x10 in the same cycle as a tick → CNT=0x10.
- Prescaler (macro on): ch3 PRESC=3, CMP=1, periodic → FLAG every 8 cycles. With the macro off, CTRL write 0x0301 reads back 0x0001.

Source files
------------

// File: rtl/iob_timer_mc.sv
// iob_timer_mc: N_CH compare/match up-counters behind a native CPU slave port, with per-channel irq.
// Define TIMER_PRESCALER_EN to build the per-channel 8-bit prescaler (CTRL[15:8]).
module iob_timer_mc #(
   parameter int N_CH = 4,
   parameter int CNT_W = 32,
   parameter int DATA_W = 32,
   parameter int ADDR_W = $clog2(N_CH) + 2
) (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0] rdata,
   output logic ready,
   output logic irq,
   output logic [N_CH-1:0] irq_vec
);
   logic [N_CH-1:0] en, periodic, irq_en, flag, tick, match;
   logic [N_CH-1:0] w_ctrl, w_cmp, w_cnt, w_st;
   logic [CNT_W-1:0] cmp [N_CH];
   logic [CNT_W-1:0] cnt [N_CH];
   logic [15:0] ctrl [N_CH];
`ifdef TIMER_PRESCALER_EN
   logic [7:0] presc [N_CH];
   logic [7:0] pcnt [N_CH];
   logic [N_CH-1:0] restart;
`endif
   logic [ADDR_W-1:0] ch;
   logic [1:0] rsel;
   logic hit, wr;
   logic [DATA_W-1:0] rd;

   assign ch = address >> 2;
   assign rsel = address[1:0];
   assign hit = valid && (32'(ch) < N_CH);
   assign wr = |wstrb;
   assign irq_vec = flag & irq_en;
   assign irq = |irq_vec;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_ctrl[i] = hit && wr && ch == ADDR_W'(i) && rsel == 2'd0;
      assign w_cmp[i] = hit && wr && ch == ADDR_W'(i) && rsel == 2'd1;
      assign w_cnt[i] = hit && wr && ch == ADDR_W'(i) && rsel == 2'd2;
      assign w_st[i] = hit && wr && ch == ADDR_W'(i) && rsel == 2'd3;
      assign match[i] = cnt[i] == cmp[i];
`ifdef TIMER_PRESCALER_EN
      assign tick[i] = en[i] && pcnt[i] == presc[i];
      // enabling or retuning the prescaler restarts its count so the first tick is predictable
      assign restart[i] = w_ctrl[i] && (wdata[15:8] != presc[i] || (wdata[0] && !en[i]));
      assign ctrl[i] = {presc[i], 5'b0, irq_en[i], periodic[i], en[i]};
`else
      assign tick[i] = en[i];
      assign ctrl[i] = {13'b0, irq_en[i], periodic[i], en[i]};
`endif
   end

   always_comb begin
      rd = '0;
      for (int i = 0; i < N_CH; i++)
         if (hit && ch == ADDR_W'(i))
            rd = rsel == 2'd0 ? DATA_W'(ctrl[i]) : rsel == 2'd1 ? DATA_W'(cmp[i]) :
                 rsel == 2'd2 ? DATA_W'(cnt[i]) : DATA_W'(flag[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b0;
         rdata <= '0;
         en <= '0;
         periodic <= '0;
         irq_en <= '0;
         flag <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cmp[i] <= '0;
            cnt[i] <= '0;
`ifdef TIMER_PRESCALER_EN
            presc[i] <= '0;
            pcnt[i] <= '0;
`endif
         end
      end else begin
         ready <= valid;
         rdata <= rd;
         for (int i = 0; i < N_CH; i++) begin
            if (w_ctrl[i]) begin
               en[i] <= wdata[0];
               periodic[i] <= wdata[1];
               irq_en[i] <= wdata[2];
            end else if (tick[i] && !w_cnt[i] && match[i] && !periodic[i])
               en[i] <= 1'b0;
            if (w_cmp[i])
               cmp[i] <= wdata[CNT_W-1:0];
            // a CNT write swallows the tick that would have happened at this edge
            if (w_cnt[i])
               cnt[i] <= wdata[CNT_W-1:0];
            else if (tick[i])
               cnt[i] <= match[i] ? (periodic[i] ? '0 : cnt[i]) : cnt[i] + CNT_W'(1);
            flag[i] <= (tick[i] && !w_cnt[i] && match[i]) || (flag[i] && !(w_st[i] && wdata[0]));
`ifdef TIMER_PRESCALER_EN
            if (w_ctrl[i])
               presc[i] <= wdata[15:8];
            if (restart[i])
               pcnt[i] <= '0;
            else if (en[i])
               pcnt[i] <= tick[i] ? '0 : pcnt[i] + 8'd1;
`endif
         end
      end
   end
endmodule
